mem_stage_sram: RTL

Memory stage directly downstream of the execute stage. It consumes the execute outputs (ALU result, Rm value, destination, control bits) and performs data-memory loads and stores against an internal word-addressed memory with a fixed multi-cycle access latency. It drives a ready/freeze handshake back to the front of the pipeline and contains the MEM/WB pipeline register feeding write-back. It also supplies the MEM-stage forwarding value used by the execute-stage source muxes.

---
 rtl/mem_stage_sram.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_sram.sv
// Memory stage: fixed-latency loads/stores against an internal word memory,
// ready/freeze handshake to the front of the pipe, and the MEM/WB register.
module mem_stage_sram #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  WB_en_in,
    input  logic [3:0]            dst_in,
    input  logic [DATA_WIDTH-1:0] ALU_res_in,
    input  logic [DATA_WIDTH-1:0] val_Rm_in,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] MEM_stage_val,
    output logic                  WB_en_out,
    output logic                  mem_read_out,
    output logic [3:0]            dst_out,
    output logic [DATA_WIDTH-1:0] ALU_res_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  addr_error_out
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] BASE_C  = DATA_WIDTH'(ADDR_BASE);
    localparam logic [DATA_WIDTH-1:0] DEPTH_C = DATA_WIDTH'(MEM_DEPTH);
    localparam logic [CW-1:0]         CNT_LOAD_C = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CW-1:0]           cnt_r;
    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    logic [DATA_WIDTH-1:0]   offset_s;
    logic [DATA_WIDTH-1:0]   word_s;
    logic [AW-1:0]           idx_s;
    logic                    valid_s;
    logic                    req_s;
    logic                    is_load_s;
    logic                    err_s;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;

    assign MEM_stage_val = ALU_res_in;

    // Address decode and per-instruction classification.
    always_comb begin
        offset_s  = ALU_res_in - BASE_C;
        word_s    = offset_s >> 2;
        idx_s     = word_s[AW-1:0];
        valid_s   = (ALU_res_in >= BASE_C) && (word_s < DEPTH_C) &&
                    (ALU_res_in[1:0] == 2'b00);
        req_s     = mem_read_in | mem_write_in;
        // A read+write collision is a store with an error, never a load.
        is_load_s = mem_read_in & ~mem_write_in;
        err_s     = req_s & (~valid_s | (mem_read_in & mem_write_in));
        mem_we_s  = rst && (state_r == ST_DONE) && mem_write_in &&
                    ~mem_read_in && valid_s;
        if (is_load_s && valid_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = '0;
        end
    end

    // FSM state register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                ST_IDLE:   cnt_r <= req_s ? CNT_LOAD_C : '0;
                ST_ACCESS: cnt_r <= (cnt_r != '0) ? cnt_r - CW'(1) : '0;
                default:   cnt_r <= '0;
            endcase
        end
    end

    // Next-state logic; DONE always returns to IDLE so it cannot re-trigger.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = (WAIT_CYCLES == 1) ? ST_DONE : ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r <= CW'(1)) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Freeze handshake; forced high while in reset.
    always_comb begin
        ready = 1'b1;
        if (!rst) begin
            ready = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE:   ready = ~req_s;
                ST_ACCESS: ready = 1'b0;
                ST_DONE:   ready = 1'b1;
                default:   ready = 1'b1;
            endcase
        end
    end

    // Data memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= val_Rm_in;
        end
    end

    // MEM/WB register: capture on ready, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WB_en_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            dst_out        <= 4'd0;
            ALU_res_out    <= '0;
            mem_data_out   <= '0;
            addr_error_out <= 1'b0;
        end else if (ready) begin
            WB_en_out      <= WB_en_in;
            mem_read_out   <= is_load_s;
            dst_out        <= dst_in;
            ALU_res_out    <= ALU_res_in;
            mem_data_out   <= rd_data_s;
            addr_error_out <= err_s;
        end else begin
            WB_en_out      <= 1'b0;
            mem_read_out   <= 1'b0;
            addr_error_out <= 1'b0;
        end
    end

endmodule
